// File: rtl/result_bcd_conv.sv
// -----------------------------------------------------------------------------
// result_bcd_conv
//
// Purpose:
//   Takes one ALU result ({din_high, din_low}, unsigned, 2*WIDTH bits) per
//   valid/ready handshake and converts it to packed BCD for the display stage.
//   The conversion is a sequential shift-add-3 (double-dabble) engine that
//   processes one binary bit per clock. The ALU zero/error flags are captured
//   on the same edge as the result and are presented with the converted value.
//   An error result skips the conversion and is shown as all-ones digits
//   (4'hF per digit, the "blank/error" code understood by the display).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_valid  in   upstream result present
//   in_ready  out  block can accept a result (IDLE only, and out of reset)
//   din_high  in   ALU result, upper half (WIDTH bits)
//   din_low   in   ALU result, lower half (WIDTH bits)
//   zero_in   in   ALU zero flag
//   error_in  in   ALU error flag
//   out_valid out  one-cycle pulse, outputs below updated this cycle
//   bcd_out   out  packed BCD, digit 0 in bits [3:0]
//   zero_out  out  captured zero flag
//   err_out   out  captured error flag
//   busy      out  conversion in progress (CONV or DONE)
//
// Timing:
//   Accepting edge -> out_valid: 2*WIDTH+1 cycles normally, 1 cycle on error.
//   DIGITS must be at least ceil(2*WIDTH*log10(2)) so the largest input fits.
// -----------------------------------------------------------------------------
module result_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      din_high,
    input  logic [WIDTH-1:0]      din_low,
    input  logic                  zero_in,
    input  logic                  error_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  zero_out,
    output logic                  err_out,
    output logic                  busy
);

    localparam int NBITS = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int CW    = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  bin_q, bin_d;          // binary shift register
    logic [BW-1:0]     scr_q, scr_d;          // BCD scratch register
    logic [BW-1:0]     scr_adj;               // scratch after the add-3 step
    logic [CW-1:0]     cnt_q, cnt_d;          // remaining shifts
    logic              zero_lat_q, zero_lat_d;
    logic              err_lat_q, err_lat_d;
    logic              out_valid_q, out_valid_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              zero_out_q, zero_out_d;
    logic              err_out_q, err_out_d;

    // Add-3 correction: any digit >= 5 would become >= 10 after the shift,
    // so pre-adding 3 makes the shift carry correctly into the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign scr_adj[4*gi +: 4] = (scr_q[4*gi +: 4] >= 4'd5)
                                        ? scr_q[4*gi +: 4] + 4'd3
                                        : scr_q[4*gi +: 4];
        end
    endgenerate

    // in_ready is held low while reset is asserted so upstream never sees a
    // handshake that the (reset-held) registers cannot take.
    assign in_ready  = (state_q == S_IDLE) && rst;
    assign busy      = (state_q == S_CONV) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign zero_out  = zero_out_q;
    assign err_out   = err_out_q;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scr_d       = scr_q;
        cnt_d       = cnt_q;
        zero_lat_d  = zero_lat_q;
        err_lat_d   = err_lat_q;
        out_valid_d = 1'b0;
        bcd_d       = bcd_q;
        zero_out_d  = zero_out_q;
        err_out_d   = err_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    bin_d      = {din_high, din_low};
                    scr_d      = '0;
                    zero_lat_d = zero_in;
                    err_lat_d  = error_in;
                    if (error_in) begin
                        // Nothing meaningful to convert; report straight away.
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CW'(NBITS);
                        state_d = S_CONV;
                    end
                end
            end

            S_CONV: begin
                {scr_d, bin_d} = {scr_adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                out_valid_d = 1'b1;
                bcd_d       = err_lat_q ? {DIGITS{4'hF}} : scr_q;
                zero_out_d  = zero_lat_q;
                err_out_d   = err_lat_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            zero_lat_q  <= 1'b0;
            err_lat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            zero_out_q  <= 1'b0;
            err_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scr_q       <= scr_d;
            cnt_q       <= cnt_d;
            zero_lat_q  <= zero_lat_d;
            err_lat_q   <= err_lat_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            zero_out_q  <= zero_out_d;
            err_out_q   <= err_out_d;
        end
    end

endmodule

// File: tb/tb_result_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_result_bcd_conv
//
// Directed stimulus pushes the expected response (BCD value, flags and the
// cycle on which out_valid must appear) into a scoreboard queue; a monitor on
// the falling edge pops and compares every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_result_bcd_conv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  din_high;
    logic [7:0]  din_low;
    logic        zero_in;
    logic        error_in;
    logic        out_valid;
    logic [19:0] bcd_out;
    logic        zero_out;
    logic        err_out;
    logic        busy;

    result_bcd_conv #(.WIDTH(8), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_high  (din_high),
        .din_low   (din_low),
        .zero_in   (zero_in),
        .error_in  (error_in),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .zero_out  (zero_out),
        .err_out   (err_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic        z;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            chk("no_back_to_back", {31'd0, prev_ov}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_out_valid: got bcd=0x%05h, expected no output", bcd_out);
            end else begin
                e = sb.pop_front();
                $display("[TB] out: bcd=0x%05h zero=%0b err=%0b cycle=%0d (exp 0x%05h %0b %0b cycle %0d)",
                         bcd_out, zero_out, err_out, cyc, e.bcd, e.z, e.e, e.cyc);
                chk("bcd_out",  {12'd0, bcd_out}, {12'd0, e.bcd});
                chk("zero_out", {31'd0, zero_out}, {31'd0, e.z});
                chk("err_out",  {31'd0, err_out},  {31'd0, e.e});
                chk("latency",  cyc, e.cyc);
            end
        end
        prev_ov <= out_valid;
    end

    task automatic push_exp(input logic [19:0] bcd, input logic z, input logic e, input int at);
        exp_t x;
        x.bcd = bcd;
        x.z   = z;
        x.e   = e;
        x.cyc = at;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input int max_cycles);
        int guard = 0;
        while (sb.size() != 0 && guard < max_cycles) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: got %0d outputs pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // One handshake from IDLE, then wait for the result.
    task automatic send(input logic [7:0] hi, input logic [7:0] lo, input logic z,
                        input logic e, input logic [19:0] exp_bcd);
        int lat;
        lat = e ? 1 : 17;
        @(negedge clk);
        din_high = hi;
        din_low  = lo;
        zero_in  = z;
        error_in = e;
        in_valid = 1'b1;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        push_exp(exp_bcd, z, e, cyc + 1 + lat);
        @(negedge clk);
        // Garbage after acceptance must not leak into the result.
        in_valid = 1'b0;
        din_high = 8'hA5;
        din_low  = 8'h5A;
        zero_in  = ~z;
        error_in = ~e;
        chk("busy_after_accept",     {31'd0, busy},     32'd1);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
        wait_drain(40);
        @(negedge clk);
        chk("in_ready_after_out", {31'd0, in_ready}, 32'd1);
        chk("busy_after_out",     {31'd0, busy},     32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        din_high = 8'h00;
        din_low  = 8'h00;
        zero_in  = 1'b0;
        error_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bcd",       {12'd0, bcd_out},   32'd0);
        chk("rst_zero",      {31'd0, zero_out},  32'd0);
        chk("rst_err",       {31'd0, err_out},   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        send(8'h00, 8'h0C, 1'b0, 1'b0, 20'h00012);   // 12
        send(8'hFE, 8'h01, 1'b0, 1'b0, 20'h65025);   // 65025
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 20'h65535);   // 65535
        send(8'h00, 8'h00, 1'b0, 1'b1, 20'hFFFFF);   // divide by zero
        send(8'h00, 8'h05, 1'b0, 1'b0, 20'h00005);   // 5
        send(8'h00, 8'h00, 1'b1, 1'b0, 20'h00000);   // zero result

        // in_valid held high with a new value every cycle: value k*1000+7.
        // Accepting edges fall at k = 0, 18, 36 (one per 18 cycles).
        for (int k = 0; k < 40; k++) begin
            logic [15:0] v;
            @(negedge clk);
            v        = 16'(k * 1000 + 7);
            din_high = v[15:8];
            din_low  = v[7:0];
            zero_in  = 1'b0;
            error_in = 1'b0;
            in_valid = 1'b1;
            chk("stream_in_ready", {31'd0, in_ready}, (k % 18 == 0) ? 32'd1 : 32'd0);
            if (k == 0)  push_exp(20'h00007, 1'b0, 1'b0, cyc + 18);
            if (k == 18) push_exp(20'h18007, 1'b0, 1'b0, cyc + 18);
            if (k == 36) push_exp(20'h36007, 1'b0, 1'b0, cyc + 18);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain(60);
        @(negedge clk);

        // Leave nonzero outputs and flags behind before the reset test.
        send(8'h00, 8'h00, 1'b1, 1'b1, 20'hFFFFF);

        // Abort 0x1234 mid-conversion; no output may appear for it.
        @(negedge clk);
        din_high = 8'h12;
        din_low  = 8'h34;
        zero_in  = 1'b0;
        error_in = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_bcd",       {12'd0, bcd_out},   32'd0);
        chk("abort_zero",      {31'd0, zero_out},  32'd0);
        chk("abort_err",       {31'd0, err_out},   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) @(negedge clk);   // monitor flags any stray out_valid here

        send(8'h00, 8'h64, 1'b0, 1'b0, 20'h00100);   // 100

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
